// File: rtl/fwd_lift.sv
// Forward ZFP lifting transform on a 4-element signed block, three-stage elastic pipeline.
// Each stage holds its own valid bit and reloads whenever it is empty or its successor can take its content.
module fwd_lift #(
    parameter int IW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*IW-1:0] s_block,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [4*IW-1:0] m_block,
    output logic            m_valid,
    input  logic            m_ready
);

    // (a+b)>>1 evaluated one bit wider so the carry out of the sum is never lost
    function automatic logic [IW-1:0] f_half(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] w_sum;
        w_sum = {a[IW-1], a} + {b[IW-1], b};
        return w_sum[IW:1];
    endfunction

    function automatic logic [IW-1:0] f_asr(input logic [IW-1:0] a);
        return {a[IW-1], a[IW-1:1]};
    endfunction

    logic            r_v1, r_v2, r_v3;
    logic [4*IW-1:0] r_d1, r_d2, r_d3;
    logic            w_ld1, w_ld2, w_ld3;

    assign w_ld3   = !r_v3 || m_ready;
    assign w_ld2   = !r_v2 || w_ld3;
    assign w_ld1   = !r_v1 || w_ld2;
    assign s_ready = reset && w_ld1;

    // S1: L1 and L2
    logic [IW-1:0] w_x0, w_y0, w_z0, w_w0;
    logic [IW-1:0] w_x1, w_y1, w_z1, w_w1;
    assign w_x0 = s_block[0*IW +: IW];
    assign w_y0 = s_block[1*IW +: IW];
    assign w_z0 = s_block[2*IW +: IW];
    assign w_w0 = s_block[3*IW +: IW];
    assign w_x1 = f_half(w_x0, w_w0);
    assign w_w1 = w_w0 - w_x1;
    assign w_z1 = f_half(w_z0, w_y0);
    assign w_y1 = w_y0 - w_z1;

    // S2: L3 and L4 touch disjoint pairs, so both run in the same cycle
    logic [IW-1:0] w_x2, w_y2, w_z2, w_w2;
    assign w_x2 = f_half(r_d1[0*IW +: IW], r_d1[2*IW +: IW]);
    assign w_z2 = r_d1[2*IW +: IW] - w_x2;
    assign w_w2 = f_half(r_d1[3*IW +: IW], r_d1[1*IW +: IW]);
    assign w_y2 = r_d1[1*IW +: IW] - w_w2;

    // S3: L5, y update uses the freshly updated w
    logic [IW-1:0] w_y3, w_w3;
    assign w_w3 = r_d2[3*IW +: IW] + f_asr(r_d2[1*IW +: IW]);
    assign w_y3 = r_d2[1*IW +: IW] - f_asr(w_w3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            if (w_ld1) r_v1 <= s_valid;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) r_v3 <= r_v2;
            if (w_ld1 && s_valid) r_d1 <= {w_w1, w_z1, w_y1, w_x1};
            if (w_ld2 && r_v1)    r_d2 <= {w_w2, w_z2, w_y2, w_x2};
            if (w_ld3 && r_v2)    r_d3 <= {w_w3, r_d2[2*IW +: IW], w_y3, r_d2[0*IW +: IW]};
        end
    end

    assign m_block = r_d3;
    assign m_valid = r_v3;

endmodule
